stage_wb_mt: RTL and testbench

STAGE_WB_MT -- requirements
Module: stage_wb_mt

---
 rtl/common.sv | 25 ++
 rtl/stage_wb_mt_if.sv | 39 +++
 rtl/exc_fifo.sv | 55 +++++
 rtl/stage_wb_mt.sv | 188 ++++++++++++++++++
 tb/tb_stage_wb_mt.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common.sv
// Shared types and constants for the multithreaded writeback stage:
// register ids, TLB-write kinds, exception causes, exception vector and boot PCs.
package common;

    typedef logic [4:0] regid_t;

    typedef enum logic [1:0] {
        TLBW_NONE = 2'd0,
        TLBW_ITLB = 2'd1,
        TLBW_DTLB = 2'd2
    } tlbwrite_t;

    typedef logic [3:0] cause_t;

    localparam cause_t CAUSE_ITLB = 4'd1;
    localparam cause_t CAUSE_DTLB = 4'd2;

    localparam logic [31:0] EXC_PC = 32'h0000_0080;

    // Each thread starts in its own 256-byte window above 0x1000.
    function automatic logic [31:0] boot_pc(input int unsigned idx);
        return 32'h0000_1000 + (idx << 8);
    endfunction

endpackage

// File: rtl/stage_wb_mt_if.sv
// Thread-local (TL) slot bundle presented to the writeback stage by the
// previous pipeline stage.
interface stage_wb_mt_if
    import common::*;
#(
    parameter int N_THREADS = 4,
    parameter int XLEN      = 32
);
    logic                         tl_valid;
    logic [$clog2(N_THREADS)-1:0] tl_thread;
    logic                         tl_isvalid;
    logic                         tl_itlb_miss;
    logic                         tl_dtlb_miss;
    regid_t                       tl_dst;
    logic [XLEN-1:0]              tl_pc;
    logic [XLEN-1:0]              tl_data;
    logic [XLEN-1:0]              tl_r2;
    logic [XLEN-1:0]              tl_mul;
    logic                         tl_isequal;
    logic                         tl_flag_mul;
    logic                         tl_flag_reg;
    logic                         tl_flag_jump;
    logic                         tl_flag_branch;
    logic                         tl_flag_iret;
    tlbwrite_t                    tl_flag_tlbwrite;

    modport master (
        output tl_valid, tl_thread, tl_isvalid, tl_itlb_miss, tl_dtlb_miss, tl_dst,
               tl_pc, tl_data, tl_r2, tl_mul, tl_isequal, tl_flag_mul, tl_flag_reg,
               tl_flag_jump, tl_flag_branch, tl_flag_iret, tl_flag_tlbwrite
    );

    modport slave (
        input  tl_valid, tl_thread, tl_isvalid, tl_itlb_miss, tl_dtlb_miss, tl_dst,
               tl_pc, tl_data, tl_r2, tl_mul, tl_isequal, tl_flag_mul, tl_flag_reg,
               tl_flag_jump, tl_flag_branch, tl_flag_iret, tl_flag_tlbwrite
    );

endinterface

// File: rtl/exc_fifo.sv
// Synchronous FIFO holding pending exceptions; push when full and pop when
// empty are ignored, so the count saturates instead of wrapping.
module exc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count == CNTW'(DEPTH));
    assign empty     = (count == {CNTW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count    <= {CNTW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= (wr_ptr_r == LAST) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= (rd_ptr_r == LAST) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/stage_wb_mt.sv
// Writeback stage for an N-thread barrel core: commits results, redirects
// threads on replay/jump/trap, and serialises exceptions through a queue.
module stage_wb_mt
    import common::*;
#(
    parameter int N_THREADS  = 4,
    parameter int XLEN       = 32,
    parameter int VPN_W      = 20,
    parameter int PPN_W      = 8,
    parameter int EXCQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    stage_wb_mt_if.slave                  tl,
    output logic [N_THREADS-1:0]          pc_redirect,
    output logic [XLEN-1:0]               pc  [N_THREADS],
    output logic [XLEN-1:0]               rm0 [N_THREADS],
    output logic [XLEN-1:0]               rm1 [N_THREADS],
    output logic [XLEN-1:0]               rm2 [N_THREADS],
    output logic [N_THREADS-1:0]          rm4,
    output logic [N_THREADS-1:0]          regfile_wen,
    output regid_t                        regfile_addr,
    output logic [XLEN-1:0]               regfile_data,
    output logic                          itlb_wen,
    output logic [VPN_W-1:0]              itlb_vpn,
    output logic [PPN_W-1:0]              itlb_ppn,
    output logic                          dtlb_wen,
    output logic [VPN_W-1:0]              dtlb_vpn,
    output logic [PPN_W-1:0]              dtlb_ppn,
    output logic                          exc_en,
    output logic [$clog2(N_THREADS)-1:0]  exc_thread,
    output logic [$clog2(EXCQ_DEPTH):0]   excq_count
);
    localparam int TW = $clog2(N_THREADS);
    localparam int CW = $bits(cause_t);
    localparam int EW = TW + 2 * XLEN + CW;
    localparam logic [XLEN-1:0] EXC_VEC = XLEN'(EXC_PC);

    logic [XLEN-1:0]      waiting_pc_r [N_THREADS];
    logic [N_THREADS-1:0] pending_r;

    logic [TW-1:0]   t_s;
    logic            accept_s, trap_s, fault_s, master_s, commit_s;
    logic            take_exc_s, push_s, pop_s, replay_s, jump_s, iret_s;
    cause_t          cause_s;
    logic [XLEN-1:0] addr_s;
    logic [EW-1:0]   push_data_s, head_s;
    logic            q_full_s, q_empty_s;
    logic [TW-1:0]   head_thread_s;
    logic [XLEN-1:0] head_pc_s, head_addr_s;
    cause_t          head_cause_s;
    logic            unused_r2_s;

    assign unused_r2_s = ^tl.tl_r2[XLEN-1:PPN_W];

    // Slot classification: the slot only counts if it matches the thread's expected PC.
    always_comb begin
        t_s         = tl.tl_thread;
        accept_s    = tl.tl_valid && (tl.tl_pc == waiting_pc_r[t_s]);
        trap_s      = accept_s && !tl.tl_isvalid && (tl.tl_itlb_miss || tl.tl_dtlb_miss);
        fault_s     = accept_s && !tl.tl_isvalid && !(tl.tl_itlb_miss || tl.tl_dtlb_miss);
        cause_s     = tl.tl_itlb_miss ? CAUSE_ITLB : CAUSE_DTLB;
        addr_s      = tl.tl_itlb_miss ? tl.tl_pc : tl.tl_data;
        master_s    = (t_s == exc_thread);
        commit_s    = accept_s && tl.tl_isvalid && (!exc_en || master_s);
        take_exc_s  = trap_s && !exc_en;
        push_s      = trap_s && exc_en && !master_s && !q_full_s && !pending_r[t_s];
        replay_s    = fault_s || (trap_s && exc_en) || (accept_s && tl.tl_isvalid && !commit_s);
        jump_s      = commit_s && tl.tl_flag_jump && (!tl.tl_flag_branch || tl.tl_isequal);
        iret_s      = jump_s && tl.tl_flag_iret;
        pop_s       = iret_s && !q_empty_s;
        push_data_s = {t_s, tl.tl_pc, cause_s, addr_s};
    end

    assign head_thread_s = head_s[EW-1 -: TW];
    assign head_pc_s     = head_s[EW-TW-1 -: XLEN];
    assign head_cause_s  = head_s[XLEN+CW-1 -: CW];
    assign head_addr_s   = head_s[XLEN-1:0];

    exc_fifo #(
        .WIDTH (EW),
        .DEPTH (EXCQ_DEPTH)
    ) u_excq (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_data_s),
        .dout  (head_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (excq_count)
    );

    // Architectural state update and single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                waiting_pc_r[i] <= XLEN'(boot_pc(i));
                pc[i]           <= XLEN'(boot_pc(i));
                rm0[i]          <= {XLEN{1'b0}};
                rm1[i]          <= {XLEN{1'b0}};
                rm2[i]          <= {XLEN{1'b0}};
            end
            rm4          <= {N_THREADS{1'b0}};
            pending_r    <= {N_THREADS{1'b0}};
            pc_redirect  <= {N_THREADS{1'b0}};
            regfile_wen  <= {N_THREADS{1'b0}};
            regfile_addr <= 5'd0;
            regfile_data <= {XLEN{1'b0}};
            itlb_wen     <= 1'b0;
            itlb_vpn     <= {VPN_W{1'b0}};
            itlb_ppn     <= {PPN_W{1'b0}};
            dtlb_wen     <= 1'b0;
            dtlb_vpn     <= {VPN_W{1'b0}};
            dtlb_ppn     <= {PPN_W{1'b0}};
            exc_en       <= 1'b0;
            exc_thread   <= {TW{1'b0}};
        end else begin
            pc_redirect <= {N_THREADS{1'b0}};
            regfile_wen <= {N_THREADS{1'b0}};
            itlb_wen    <= 1'b0;
            dtlb_wen    <= 1'b0;

            if (replay_s) begin
                pc[t_s]          <= tl.tl_pc;
                pc_redirect[t_s] <= 1'b1;
            end
            if (push_s) pending_r[t_s] <= 1'b1;

            if (take_exc_s) begin
                exc_en            <= 1'b1;
                exc_thread        <= t_s;
                pc[t_s]           <= EXC_VEC;
                waiting_pc_r[t_s] <= EXC_VEC;
                pc_redirect[t_s]  <= 1'b1;
                rm0[t_s]          <= tl.tl_pc;
                rm1[t_s]          <= addr_s;
                rm2[t_s]          <= XLEN'(cause_s);
                rm4[t_s]          <= 1'b1;
            end

            if (commit_s) begin
                waiting_pc_r[t_s] <= tl.tl_pc + XLEN'(4);
                if (tl.tl_flag_reg) begin
                    regfile_wen[t_s] <= 1'b1;
                    regfile_addr     <= tl.tl_dst;
                    regfile_data     <= tl.tl_flag_mul ? tl.tl_mul : tl.tl_data;
                end
                if (tl.tl_flag_tlbwrite == TLBW_ITLB) begin
                    itlb_wen <= 1'b1;
                    itlb_vpn <= tl.tl_data[VPN_W-1:0];
                    itlb_ppn <= tl.tl_r2[PPN_W-1:0];
                end
                if (tl.tl_flag_tlbwrite == TLBW_DTLB) begin
                    dtlb_wen <= 1'b1;
                    dtlb_vpn <= tl.tl_data[VPN_W-1:0];
                    dtlb_ppn <= tl.tl_r2[PPN_W-1:0];
                end
                // iret returns to rm0 and hands the exception to the oldest waiter, if any.
                if (iret_s) begin
                    pc[t_s]           <= rm0[t_s];
                    waiting_pc_r[t_s] <= rm0[t_s];
                    pc_redirect[t_s]  <= 1'b1;
                    rm4[t_s]          <= 1'b0;
                    if (pop_s) begin
                        exc_thread                  <= head_thread_s;
                        pc[head_thread_s]           <= EXC_VEC;
                        waiting_pc_r[head_thread_s] <= EXC_VEC;
                        pc_redirect[head_thread_s]  <= 1'b1;
                        rm0[head_thread_s]          <= head_pc_s;
                        rm1[head_thread_s]          <= head_addr_s;
                        rm2[head_thread_s]          <= XLEN'(head_cause_s);
                        rm4[head_thread_s]          <= 1'b1;
                        pending_r[head_thread_s]    <= 1'b0;
                    end else begin
                        exc_en <= 1'b0;
                    end
                end else if (jump_s) begin
                    pc[t_s]           <= tl.tl_data;
                    waiting_pc_r[t_s] <= tl.tl_data;
                    pc_redirect[t_s]  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_wb_mt.sv
// Directed bench for stage_wb_mt: a queue-based reference model is compared
// against the DUT every cycle, plus hand-computed literal spot checks.
module tb_stage_wb_mt;
    import common::*;

    localparam int NT = 4;
    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_EQ   = 6'b000001;
    localparam logic [5:0] F_MUL  = 6'b000010;
    localparam logic [5:0] F_REG  = 6'b000100;
    localparam logic [5:0] F_JMP  = 6'b001000;
    localparam logic [5:0] F_BR   = 6'b010000;
    localparam logic [5:0] F_IRET = 6'b100000;

    logic clk;
    logic rst;

    stage_wb_mt_if #(.N_THREADS(NT), .XLEN(32)) tl ();

    logic [NT-1:0] pc_redirect;
    logic [31:0]   pc  [NT];
    logic [31:0]   rm0 [NT];
    logic [31:0]   rm1 [NT];
    logic [31:0]   rm2 [NT];
    logic [NT-1:0] rm4;
    logic [NT-1:0] regfile_wen;
    regid_t        regfile_addr;
    logic [31:0]   regfile_data;
    logic          itlb_wen, dtlb_wen;
    logic [19:0]   itlb_vpn, dtlb_vpn;
    logic [7:0]    itlb_ppn, dtlb_ppn;
    logic          exc_en;
    logic [1:0]    exc_thread;
    logic [2:0]    excq_count;

    stage_wb_mt #(
        .N_THREADS(NT), .XLEN(32), .VPN_W(20), .PPN_W(8), .EXCQ_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .tl(tl),
        .pc_redirect(pc_redirect), .pc(pc), .rm0(rm0), .rm1(rm1), .rm2(rm2), .rm4(rm4),
        .regfile_wen(regfile_wen), .regfile_addr(regfile_addr), .regfile_data(regfile_data),
        .itlb_wen(itlb_wen), .itlb_vpn(itlb_vpn), .itlb_ppn(itlb_ppn),
        .dtlb_wen(dtlb_wen), .dtlb_vpn(dtlb_vpn), .dtlb_ppn(dtlb_ppn),
        .exc_en(exc_en), .exc_thread(exc_thread), .excq_count(excq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int          t;
        logic [31:0] p;
        logic [31:0] cause;
        logic [31:0] addr;
    } qent_t;

    logic [31:0] m_wpc [NT];
    logic [31:0] m_pc  [NT];
    logic [31:0] m_rm0 [NT];
    logic [31:0] m_rm1 [NT];
    logic [31:0] m_rm2 [NT];
    logic [NT-1:0] m_rm4;
    logic        m_exc;
    int          m_master;
    qent_t       q [$];
    logic [NT-1:0] e_redirect, e_rwen;
    logic [4:0]  e_raddr;
    logic [31:0] e_rdata;
    logic        e_iwen, e_dwen;
    logic [19:0] e_ivpn, e_dvpn;
    logic [7:0]  e_ippn, e_dppn;

    int  n_checks;
    int  n_err;
    logic check_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_pulses();
        e_redirect = '0;
        e_rwen     = '0;
        e_iwen     = 1'b0;
        e_dwen     = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_wpc[i] = 32'h1000 + 32'(i) * 32'h100;
            m_pc[i]  = m_wpc[i];
            m_rm0[i] = 32'd0;
            m_rm1[i] = 32'd0;
            m_rm2[i] = 32'd0;
        end
        m_rm4    = '0;
        m_exc    = 1'b0;
        m_master = 0;
        q.delete();
        clear_pulses();
    endtask

    task automatic replay(input int t, input logic [31:0] p);
        m_pc[t]       = p;
        e_redirect[t] = 1'b1;
    endtask

    task automatic enter_exc(input int t, input logic [31:0] p, input logic [31:0] cause,
                             input logic [31:0] addr);
        m_master      = t;
        m_pc[t]       = 32'h80;
        m_wpc[t]      = 32'h80;
        e_redirect[t] = 1'b1;
        m_rm0[t]      = p;
        m_rm1[t]      = addr;
        m_rm2[t]      = cause;
        m_rm4[t]      = 1'b1;
    endtask

    // Apply the rules of the stage to the slot currently driven on tl.
    task automatic model_step();
        int          t;
        logic [31:0] p, cause, addr;
        bit          queued;
        qent_t       h;
        clear_pulses();
        t = int'(tl.tl_thread);
        p = tl.tl_pc;
        if (tl.tl_valid && p == m_wpc[t]) begin
            if (!tl.tl_isvalid) begin
                if (tl.tl_itlb_miss || tl.tl_dtlb_miss) begin
                    cause = tl.tl_itlb_miss ? 32'd1 : 32'd2;
                    addr  = tl.tl_itlb_miss ? p : tl.tl_data;
                    if (!m_exc) begin
                        m_exc = 1'b1;
                        enter_exc(t, p, cause, addr);
                    end else begin
                        queued = 1'b0;
                        foreach (q[k]) if (q[k].t == t) queued = 1'b1;
                        if (t != m_master && q.size() < 4 && !queued)
                            q.push_back('{t, p, cause, addr});
                        replay(t, p);
                    end
                end else begin
                    replay(t, p);
                end
            end else if (m_exc && t != m_master) begin
                replay(t, p);
            end else begin
                m_wpc[t] = p + 32'd4;
                if (tl.tl_flag_reg) begin
                    e_rwen[t] = 1'b1;
                    e_raddr   = tl.tl_dst;
                    e_rdata   = tl.tl_flag_mul ? tl.tl_mul : tl.tl_data;
                end
                if (tl.tl_flag_tlbwrite == TLBW_ITLB) begin
                    e_iwen = 1'b1; e_ivpn = tl.tl_data[19:0]; e_ippn = tl.tl_r2[7:0];
                end
                if (tl.tl_flag_tlbwrite == TLBW_DTLB) begin
                    e_dwen = 1'b1; e_dvpn = tl.tl_data[19:0]; e_dppn = tl.tl_r2[7:0];
                end
                if (tl.tl_flag_jump && (!tl.tl_flag_branch || tl.tl_isequal)) begin
                    if (tl.tl_flag_iret) begin
                        m_pc[t]  = m_rm0[t];
                        m_wpc[t] = m_rm0[t];
                        e_redirect[t] = 1'b1;
                        m_rm4[t] = 1'b0;
                        if (q.size() == 0) begin
                            m_exc = 1'b0;
                        end else begin
                            h = q.pop_front();
                            enter_exc(h.t, h.p, h.cause, h.addr);
                        end
                    end else begin
                        m_pc[t]  = tl.tl_data;
                        m_wpc[t] = tl.tl_data;
                        e_redirect[t] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("pc_redirect", 64'(pc_redirect), 64'(e_redirect));
        chk("regfile_wen", 64'(regfile_wen), 64'(e_rwen));
        chk("itlb_wen", 64'(itlb_wen), 64'(e_iwen));
        chk("dtlb_wen", 64'(dtlb_wen), 64'(e_dwen));
        chk("rm4", 64'(rm4), 64'(m_rm4));
        chk("exc_en", 64'(exc_en), 64'(m_exc));
        chk("exc_thread", 64'(exc_thread), 64'(m_master));
        chk("excq_count", 64'(excq_count), 64'(q.size()));
        for (int i = 0; i < NT; i++) begin
            chk($sformatf("pc[%0d]", i), 64'(pc[i]), 64'(m_pc[i]));
            chk($sformatf("rm0[%0d]", i), 64'(rm0[i]), 64'(m_rm0[i]));
            chk($sformatf("rm1[%0d]", i), 64'(rm1[i]), 64'(m_rm1[i]));
            chk($sformatf("rm2[%0d]", i), 64'(rm2[i]), 64'(m_rm2[i]));
        end
        if (e_rwen != '0) begin
            chk("regfile_addr", 64'(regfile_addr), 64'(e_raddr));
            chk("regfile_data", 64'(regfile_data), 64'(e_rdata));
        end
        if (e_iwen) begin
            chk("itlb_vpn", 64'(itlb_vpn), 64'(e_ivpn));
            chk("itlb_ppn", 64'(itlb_ppn), 64'(e_ippn));
        end
        if (e_dwen) begin
            chk("dtlb_vpn", 64'(dtlb_vpn), 64'(e_dvpn));
            chk("dtlb_ppn", 64'(dtlb_ppn), 64'(e_dppn));
        end
    endtask

    // Single compare process: outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (check_en) compare();
    end

    task automatic set_idle();
        tl.tl_valid = 1'b0; tl.tl_thread = 2'd0; tl.tl_isvalid = 1'b0;
        tl.tl_itlb_miss = 1'b0; tl.tl_dtlb_miss = 1'b0; tl.tl_dst = 5'd0;
        tl.tl_pc = 32'd0; tl.tl_data = 32'd0; tl.tl_r2 = 32'd0; tl.tl_mul = 32'd0;
        tl.tl_isequal = 1'b0; tl.tl_flag_mul = 1'b0; tl.tl_flag_reg = 1'b0;
        tl.tl_flag_jump = 1'b0; tl.tl_flag_branch = 1'b0; tl.tl_flag_iret = 1'b0;
        tl.tl_flag_tlbwrite = TLBW_NONE;
    endtask

    task automatic idle();
        @(negedge clk);
        set_idle();
        model_step();
    endtask

    task automatic slot(input int t, input logic [31:0] p, input logic isv, input logic im,
                        input logic dm, input logic [31:0] data, input logic [5:0] fl,
                        input tlbwrite_t tw = TLBW_NONE, input logic [4:0] dst = 5'd0,
                        input logic [31:0] r2 = 32'd0, input logic [31:0] mul = 32'd0);
        @(negedge clk);
        tl.tl_valid = 1'b1; tl.tl_thread = t[1:0]; tl.tl_isvalid = isv;
        tl.tl_itlb_miss = im; tl.tl_dtlb_miss = dm; tl.tl_dst = dst;
        tl.tl_pc = p; tl.tl_data = data; tl.tl_r2 = r2; tl.tl_mul = mul;
        tl.tl_isequal = fl[0]; tl.tl_flag_mul = fl[1]; tl.tl_flag_reg = fl[2];
        tl.tl_flag_jump = fl[3]; tl.tl_flag_branch = fl[4]; tl.tl_flag_iret = fl[5];
        tl.tl_flag_tlbwrite = tw;
        model_step();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        set_idle();
        model_reset();
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle();
        settle();
        chk("lit_reset_pc1", 64'(pc[1]), 64'h1100);
        chk("lit_reset_exc_en", 64'(exc_en), 64'h0);
        chk("lit_reset_redirect", 64'(pc_redirect), 64'h0);

        // Thread 1 commit at boot PC, then the next PC proves waiting_pc advanced.
        slot(1, 32'h1100, 1'b1, 1'b0, 1'b0, 32'd5, F_REG, TLBW_NONE, 5'd3);
        settle();
        chk("lit_wen_t1", 64'(regfile_wen), 64'b0010);
        chk("lit_wdata_t1", 64'(regfile_data), 64'h5);
        idle();
        settle();
        chk("lit_wen_cleared", 64'(regfile_wen), 64'h0);
        slot(1, 32'h1100, 1'b1, 1'b0, 1'b0, 32'h3000, F_REG | F_JMP);
        settle();
        chk("lit_stale_wen", 64'(regfile_wen), 64'h0);
        chk("lit_stale_redirect", 64'(pc_redirect), 64'h0);
        slot(1, 32'h1104, 1'b1, 1'b0, 1'b0, 32'd7, F_REG, TLBW_NONE, 5'd4);
        settle();
        chk("lit_wen_next", 64'(regfile_wen), 64'b0010);
        slot(1, 32'h1108, 1'b1, 1'b0, 1'b0, 32'd7, F_REG | F_MUL, TLBW_NONE, 5'd5, 32'd0, 32'h99);
        settle();
        chk("lit_mul_data", 64'(regfile_data), 64'h99);
        slot(1, 32'h110C, 1'b1, 1'b0, 1'b0, 32'hABCD_E123, F_NONE, TLBW_ITLB, 5'd0, 32'h5A);
        settle();
        chk("lit_itlb_vpn", 64'(itlb_vpn), 64'hDE123);

        // Branch not taken, taken branch, commit at the branch target.
        slot(1, 32'h1110, 1'b1, 1'b0, 1'b0, 32'h2000, F_JMP | F_BR);
        settle();
        chk("lit_nt_redirect", 64'(pc_redirect), 64'h0);
        slot(1, 32'h1114, 1'b1, 1'b0, 1'b0, 32'd9, F_REG, TLBW_NONE, 5'd6);
        slot(1, 32'h1118, 1'b1, 1'b0, 1'b0, 32'h2000, F_JMP | F_BR | F_EQ);
        settle();
        chk("lit_taken_pc1", 64'(pc[1]), 64'h2000);
        slot(1, 32'h2000, 1'b1, 1'b0, 1'b0, 32'd1, F_REG, TLBW_NONE, 5'd7);

        // Thread 0: plain fault replay, DTLB write, then a DTLB-miss trap.
        slot(0, 32'h1000, 1'b0, 1'b0, 1'b0, 32'd0, F_NONE);
        settle();
        chk("lit_replay_redirect", 64'(pc_redirect), 64'b0001);
        slot(0, 32'h1000, 1'b1, 1'b0, 1'b0, 32'h0001_2345, F_NONE, TLBW_DTLB, 5'd0, 32'h1FF);
        settle();
        chk("lit_dtlb_ppn", 64'(dtlb_ppn), 64'hFF);
        slot(0, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h1234, F_NONE);
        settle();
        chk("lit_trap_exc_en", 64'(exc_en), 64'h1);
        chk("lit_trap_pc0", 64'(pc[0]), 64'h80);
        chk("lit_trap_rm1", 64'(rm1[0]), 64'h1234);
        chk("lit_trap_rm4", 64'(rm4), 64'b0001);

        // Non-master traps queue once each; non-master commit is replayed.
        slot(2, 32'h1200, 1'b0, 1'b1, 1'b0, 32'd0, F_NONE);
        slot(3, 32'h1300, 1'b0, 1'b1, 1'b0, 32'd0, F_NONE);
        settle();
        chk("lit_q_two", 64'(excq_count), 64'h2);
        slot(2, 32'h1200, 1'b0, 1'b1, 1'b0, 32'd0, F_NONE);
        settle();
        chk("lit_q_still_two", 64'(excq_count), 64'h2);
        chk("lit_q_replay", 64'(pc_redirect), 64'b0100);
        slot(1, 32'h2004, 1'b1, 1'b0, 1'b0, 32'd1, F_REG);
        settle();
        chk("lit_nonmaster_wen", 64'(regfile_wen), 64'h0);
        slot(0, 32'h80, 1'b1, 1'b0, 1'b0, 32'd1, F_REG, TLBW_NONE, 5'd1);

        // iret chain: 0 -> 2 -> 3 -> exception state clear.
        slot(0, 32'h84, 1'b1, 1'b0, 1'b0, 32'd0, F_JMP | F_IRET);
        settle();
        chk("lit_iret_pc0", 64'(pc[0]), 64'h1004);
        chk("lit_iret_master", 64'(exc_thread), 64'h2);
        chk("lit_iret_pc2", 64'(pc[2]), 64'h80);
        chk("lit_iret_q", 64'(excq_count), 64'h1);
        chk("lit_iret_redirect", 64'(pc_redirect), 64'b0101);
        slot(2, 32'h80, 1'b1, 1'b0, 1'b0, 32'd0, F_JMP | F_IRET);
        slot(3, 32'h80, 1'b1, 1'b0, 1'b0, 32'd0, F_JMP | F_IRET);
        settle();
        chk("lit_final_exc_en", 64'(exc_en), 64'h0);
        chk("lit_final_pc3", 64'(pc[3]), 64'h1300);

        // Reset in the middle of an exception discards the queue.
        slot(0, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h55, F_NONE);
        slot(1, 32'h2004, 1'b0, 1'b1, 1'b0, 32'd0, F_NONE);
        settle();
        chk("lit_pre_reset_q", 64'(excq_count), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        model_reset();
        settle();
        chk("lit_mid_reset_q", 64'(excq_count), 64'h0);
        chk("lit_mid_reset_pc1", 64'(pc[1]), 64'h1100);
        @(negedge clk);
        rst = 1'b1;
        slot(1, 32'h1100, 1'b1, 1'b0, 1'b0, 32'd2, F_REG);
        idle();
        idle();
        settle();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
